// File: rtl/gpio_in.sv
// Memory-mapped GPIO input block: two-flop synchroniser, optional prescaled debounce,
// write-1-to-clear edge status and a level interrupt for enabled pending edges.
module gpio_in #(
    parameter logic [21:0] BASE_PAGE = 22'd2,
    parameter int          NPINS     = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NPINS-1:0] gpio_i,
    input  logic [31:0]      data_addr,
    input  logic             datamem_rd,
    input  logic [3:0]       datamem_wr,
    input  logic [7:0]       data_wr0,
    input  logic [7:0]       data_wr1,
    input  logic [7:0]       data_wr2,
    input  logic [7:0]       data_wr3,
    output logic [31:0]      data_rd,
    output logic             irq
);

    logic [NPINS-1:0] sync1_q, sync2_q, stable_q, stable_d, sample_q, sample_d;
    logic [15:0]      presc_q, presc_d, deb_q, deb_d, ie_q, ie_d, status_q, status_d;
    logic [15:0]      set_s, w1c_s, wmask_s, wdata_s;
    logic [31:0]      data_rd_q, data_rd_d, rd_word_s;
    logic             sel_s;
    logic [1:0]       offset_s;

    // Lanes 2/3 and the aliased address bits are deliberately not decoded.
    logic unused_ok_s;
    assign unused_ok_s = ^{data_addr[9:4], data_addr[1:0], data_wr2, data_wr3, datamem_wr[3:2]};

    assign sel_s    = (data_addr[31:10] == BASE_PAGE);
    assign offset_s = data_addr[3:2];
    assign wmask_s  = {{8{datamem_wr[1]}}, {8{datamem_wr[0]}}};
    assign wdata_s  = {data_wr1, data_wr0};

    // Register writes, debounce/prescaler and edge-status next state.
    always_comb begin
        ie_d     = ie_q;
        deb_d    = deb_q;
        w1c_s    = 16'h0000;
        stable_d = stable_q;
        sample_d = sample_q;
        presc_d  = presc_q;
        set_s    = 16'h0000;
        if (sel_s) begin
            case (offset_s)
                2'b01:   ie_d  = (ie_q & ~wmask_s) | (wdata_s & wmask_s);
                2'b10:   w1c_s = wdata_s & wmask_s;
                2'b11:   deb_d = (deb_q & ~wmask_s) | (wdata_s & wmask_s);
                default: ie_d  = ie_q;
            endcase
        end else begin
            ie_d = ie_q;
        end
        if (deb_q == 16'h0000) begin
            stable_d = sync2_q;
            presc_d  = 16'h0000;
        end else if (presc_q == 16'h0000) begin
            // A bit only moves when it matched at two consecutive ticks.
            presc_d  = deb_q;
            sample_d = sync2_q;
            stable_d = (sync2_q & ~(sync2_q ^ sample_q)) | (stable_q & (sync2_q ^ sample_q));
        end else begin
            presc_d = presc_q - 16'd1;
        end
        if (sel_s && (offset_s == 2'b11) && (datamem_wr[1:0] != 2'b00)) begin
            presc_d = deb_d;
        end else begin
            presc_d = presc_d;
        end
        for (int i = 0; i < NPINS; i++) begin
            set_s[i]     = stable_d[i] & ~stable_q[i];
            set_s[8 + i] = ~stable_d[i] & stable_q[i];
        end
        status_d = (status_q & ~w1c_s) | set_s;
    end

    // Read mux; unused bits read as zero.
    always_comb begin
        rd_word_s = 32'h0000_0000;
        case (offset_s)
            2'b00:   rd_word_s[NPINS-1:0] = stable_q;
            2'b01:   rd_word_s[15:0]      = ie_q;
            2'b10:   rd_word_s[15:0]      = status_q;
            2'b11:   rd_word_s[15:0]      = deb_q;
            default: rd_word_s            = 32'h0000_0000;
        endcase
        if (sel_s && datamem_rd) begin
            data_rd_d = rd_word_s;
        end else begin
            data_rd_d = 32'h0000_0000;
        end
    end

    // All state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            sample_q  <= '0;
            presc_q   <= 16'h0000;
            deb_q     <= 16'h0000;
            ie_q      <= 16'h0000;
            status_q  <= 16'h0000;
            data_rd_q <= 32'h0000_0000;
        end else begin
            sync1_q   <= gpio_i;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            sample_q  <= sample_d;
            presc_q   <= presc_d;
            deb_q     <= deb_d;
            ie_q      <= ie_d;
            status_q  <= status_d;
            data_rd_q <= data_rd_d;
        end
    end

    assign data_rd = data_rd_q;
    assign irq     = |(status_q & ie_q);

endmodule

// File: tb/tb_gpio_in.sv
// Directed self-checking bench for gpio_in with hand-computed expectations.
module tb_gpio_in;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  gpio_i;
    logic [31:0] data_addr;
    logic        datamem_rd;
    logic [3:0]  datamem_wr;
    logic [7:0]  data_wr0, data_wr1, data_wr2, data_wr3;
    logic [31:0] data_rd;
    logic        irq;

    int total = 0;
    int bad   = 0;
    logic found;
    int   n;

    gpio_in #(.BASE_PAGE(22'd2), .NPINS(8)) dut (
        .clk(clk), .rstn(rstn), .gpio_i(gpio_i), .data_addr(data_addr),
        .datamem_rd(datamem_rd), .datamem_wr(datamem_wr),
        .data_wr0(data_wr0), .data_wr1(data_wr1), .data_wr2(data_wr2), .data_wr3(data_wr3),
        .data_rd(data_rd), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [7:0] d0, input logic [7:0] d1);
        data_addr  = a;
        datamem_wr = be;
        data_wr0   = d0;
        data_wr1   = d1;
        data_wr2   = 8'hFF;
        data_wr3   = 8'hFF;
        step();
        datamem_wr = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] a);
        data_addr  = a;
        datamem_rd = 1'b1;
        step();
        datamem_rd = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; gpio_i = 8'hFF; data_addr = 32'h0; datamem_rd = 1'b0;
        datamem_wr = 4'b0000; data_wr0 = 8'h00; data_wr1 = 8'h00; data_wr2 = 8'h00; data_wr3 = 8'h00;
        step(); step();
        chk("rst_irq", {31'd0, irq}, 32'h0);
        chk("rst_data_rd", data_rd, 32'h0);
        rstn = 1'b1;
        step();
        rd(32'h0000_0800);
        chk("rst_data_early", data_rd, 32'h0);
        step();
        rd(32'h0000_0800);
        chk("rst_data_ff", data_rd, 32'h0000_00FF);

        // Park pins at 0x08, clear status, enable bit0 rise only.
        gpio_i = 8'h08;
        step(); step(); step();
        wr(32'h0000_0808, 4'b0011, 8'hFF, 8'hFF);
        wr(32'h0000_0804, 4'b0011, 8'h01, 8'h00);
        rd(32'h0000_0808);
        chk("status_cleared", data_rd, 32'h0);
        chk("irq_idle", {31'd0, irq}, 32'h0);

        gpio_i = 8'h09;
        step();
        chk("irq_k", {31'd0, irq}, 32'h0);
        step();
        chk("irq_k1", {31'd0, irq}, 32'h0);
        step();
        chk("irq_k2", {31'd0, irq}, 32'h1);
        rd(32'h0000_0808);
        chk("status_rise0", data_rd, 32'h0000_0001);
        gpio_i = 8'h01;
        step(); step(); step();
        rd(32'h0000_0808);
        chk("status_fall3", data_rd, 32'h0000_0801);
        chk("irq_after_fall3", {31'd0, irq}, 32'h1);

        wr(32'h0000_0808, 4'b0001, 8'h01, 8'h00);
        chk("w1c_irq", {31'd0, irq}, 32'h0);
        rd(32'h0000_0808);
        chk("w1c_status", data_rd, 32'h0000_0800);

        gpio_i = 8'h00;
        step(); step(); step();
        gpio_i = 8'h01;
        step(); step();
        wr(32'h0000_0808, 4'b0001, 8'h01, 8'h00);
        chk("set_wins_irq", {31'd0, irq}, 32'h1);
        rd(32'h0000_0808);
        chk("set_wins_status", data_rd, 32'h0000_0901);

        // Debounce with a 4-cycle tick.
        wr(32'h0000_0808, 4'b0011, 8'hFF, 8'hFF);
        wr(32'h0000_0804, 4'b0011, 8'h00, 8'h00);
        wr(32'h0000_080C, 4'b0011, 8'h03, 8'h00);
        step();
        gpio_i = 8'h03;
        step(); step();
        gpio_i = 8'h01;
        for (int i = 0; i < 10; i++) step();
        rd(32'h0000_0800);
        chk("glitch_data", data_rd, 32'h0000_0001);
        rd(32'h0000_0808);
        chk("glitch_status", data_rd, 32'h0);

        gpio_i = 8'h03;
        data_addr = 32'h0000_0800;
        datamem_rd = 1'b1;
        found = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (!found && data_rd[1]) begin
                found = 1'b1;
                n = i + 1;
            end
        end
        datamem_rd = 1'b0;
        chk("deb_seen", {31'd0, found}, 32'h1);
        chk("deb_latency", {31'd0, (n >= 7) && (n <= 11)}, 32'h1);
        rd(32'h0000_0808);
        chk("deb_status", data_rd, 32'h0000_0002);

        // Decode and byte lanes.
        wr(32'h0000_0404, 4'b0011, 8'hFF, 8'hFF);
        wr(32'h0000_0804, 4'b1100, 8'hFF, 8'hFF);
        rd(32'h0000_0804);
        chk("ie_no_change", data_rd, 32'h0);
        wr(32'h0000_0804, 4'b0010, 8'h55, 8'hAA);
        rd(32'h0000_0804);
        chk("ie_lane1", data_rd, 32'h0000_AA00);
        rd(32'h0000_08F4);
        chk("ie_alias", data_rd, 32'h0000_AA00);
        rd(32'h0000_0404);
        chk("rd_unsel", data_rd, 32'h0);

        // Reset while debouncing with pending status.
        wr(32'h0000_080C, 4'b0011, 8'h00, 8'h00);
        gpio_i = 8'h00;
        step(); step(); step();
        wr(32'h0000_0808, 4'b0011, 8'hFF, 8'hFF);
        gpio_i = 8'hFF;
        step(); step(); step();
        rd(32'h0000_0808);
        chk("pre_rst_status", data_rd, 32'h0000_00FF);
        wr(32'h0000_080C, 4'b0011, 8'h03, 8'h00);
        step(); step();
        rstn = 1'b0;
        step();
        chk("mid_rst_irq", {31'd0, irq}, 32'h0);
        rstn = 1'b1;
        rd(32'h0000_0808);
        chk("mid_rst_status", data_rd, 32'h0);
        rd(32'h0000_080C);
        chk("mid_rst_debounce", data_rd, 32'h0);
        step(); step();
        rd(32'h0000_0808);
        chk("bypass_status", data_rd, 32'h0000_00FF);
        rd(32'h0000_0800);
        chk("bypass_data", data_rd, 32'h0000_00FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
